uart_tx_arbiter: RTL

Round-robin scheduler that shares the single UART transmitter (clk_3125 domain, feeding the HC-05 link) among up to four message sources: line-follower status, sensor telemetry, event logs and debug. Each source requests a multi-byte message. The block grants one source at a time and sequences its bytes into the transmitter with a one-cycle start pulse per byte. It waits for the transmitter's done pulse before moving on, and aborts on a stuck link via a watchdog.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message sources, the UART transmit arbiter and the UART transmitter.
// The master modport is the arbiter's view; the slave modport is the sources/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_len;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_parity;
    logic [N_REQ-1:0]   grant;
    logic [3:0]         byte_idx;
    logic [N_REQ-1:0]   done;
    logic               err;
    logic               busy;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_parity;
    logic               tx_done;

    modport master (
        input  req, req_len, req_data, req_parity, tx_done,
        output grant, byte_idx, done, err, busy, tx_start, tx_data, tx_parity
    );

    modport slave (
        output req, req_len, req_data, req_parity, tx_done,
        input  grant, byte_idx, done, err, busy, tx_start, tx_data, tx_parity
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among up to four message sources,
// sequencing each granted message byte by byte with a watchdog on the transmitter's done pulse.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 400
) (
    input  logic              clk_3125,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, NEXT} state_t;

    localparam logic [9:0] TMO  = 10'(TIMEOUT);
    localparam logic [1:0] LAST = 2'(N_REQ - 1);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant_q, grant_nxt;
    logic [N_REQ-1:0] done_q, done_nxt;
    logic [1:0]       rr_ptr, rr_nxt;
    logic [1:0]       winner, winner_nxt;
    logic [3:0]       idx_q, idx_nxt;
    logic [3:0]       len_q, len_nxt;
    logic [9:0]       wd_q, wd_nxt, wd_inc;
    logic [7:0]       data_q, data_nxt;
    logic             par_q, par_nxt;
    logic             err_q, err_nxt;
    logic             start_q, start_nxt;

    logic             found;
    logic [1:0]       pick;
    logic [2:0]       cand;
    logic [3:0]       pick_len;

    function automatic logic [1:0] rr_after(input logic [1:0] w);
        return (w == LAST) ? 2'd0 : w + 2'd1;
    endfunction

    // First requesting source at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + 3'(i);
            if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
            if (!found && bus.req[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    assign pick_len = bus.req_len[{pick, 2'b00} +: 4];

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        winner_nxt = winner;
        rr_nxt     = rr_ptr;
        idx_nxt    = idx_q;
        len_nxt    = len_q;
        wd_nxt     = wd_q;
        data_nxt   = data_q;
        par_nxt    = par_q;
        done_nxt   = '0;
        err_nxt    = 1'b0;
        start_nxt  = 1'b0;
        wd_inc     = wd_q + 10'd1;
        case (state)
            IDLE: begin
                if (found) begin
                    if (pick_len == 4'd0) begin
                        done_nxt[pick] = 1'b1;
                        rr_nxt         = rr_after(pick);
                    end else begin
                        grant_nxt       = '0;
                        grant_nxt[pick] = 1'b1;
                        winner_nxt      = pick;
                        par_nxt         = bus.req_parity[pick];
                        len_nxt         = pick_len;
                        idx_nxt         = '0;
                        state_nxt       = LOAD;
                    end
                end
            end
            LOAD: begin
                data_nxt  = bus.req_data[{winner, 3'b000} +: 8];
                start_nxt = 1'b1;
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Abort decided on the count including this cycle, so err lands exactly
                // TIMEOUT cycles after WAIT is entered.
                if (bus.tx_done) begin
                    state_nxt = NEXT;
                end else if (wd_inc == TMO) begin
                    err_nxt   = 1'b1;
                    grant_nxt = '0;
                    rr_nxt    = rr_after(winner);
                    state_nxt = IDLE;
                end else begin
                    wd_nxt = wd_inc;
                end
            end
            NEXT: begin
                if (!bus.req[winner]) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else if (idx_q == len_q - 4'd1) begin
                    done_nxt[winner] = 1'b1;
                    grant_nxt        = '0;
                    rr_nxt           = rr_after(winner);
                    state_nxt        = IDLE;
                end else begin
                    idx_nxt   = idx_q + 4'd1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rr_ptr  <= '0;
            winner  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            rr_ptr  <= rr_nxt;
            winner  <= winner_nxt;
            idx_q   <= idx_nxt;
            len_q   <= len_nxt;
            wd_q    <= wd_nxt;
            data_q  <= data_nxt;
            par_q   <= par_nxt;
            err_q   <= err_nxt;
            start_q <= start_nxt;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.byte_idx  = idx_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_parity = par_q;
endmodule
